// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a combinational-read data memory.
// Optional address checking is enabled with `define DMEM_ARB_ALIGN_CHK_EN.
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int unsigned Width = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [Width-1:0] A0,
  input  logic [Width-1:0] A1,
  input  logic [Width-1:0] WD0,
  input  logic [Width-1:0] WD1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [Width-1:0] RD,
  output logic             ERR,
  output logic             BUSY,
  output logic [Width-1:0] MEM_A,
  output logic [Width-1:0] MEM_WD,
  output logic             MEM_WE,
  input  logic [Width-1:0] MEM_RD
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;   // 1 = port 1 was granted last
  logic             we_q, we_d;
  logic             rej_q, rej_d;
  logic             win1, sel_we, rej;
  logic [Width-1:0] sel_a, sel_wd;
  logic             gnt0_d, gnt1_d, done0_d, done1_d, err_d, busy_d, mem_we_d;
  logic [Width-1:0] rd_d, mem_a_d, mem_wd_d;

  // Winner select and next-state / next-output computation
  always_comb begin
    win1   = REQ1 & (~REQ0 | ~last_q);
    sel_a  = win1 ? A1  : A0;
    sel_wd = win1 ? WD1 : WD0;
    sel_we = win1 ? WE1 : WE0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    rej    = (sel_a[1:0] != 2'b00) || (sel_a > Width'(DEPTH - 4));
`else
    rej    = 1'b0;
`endif

    state_d  = state_q;
    last_d   = last_q;
    we_d     = we_q;
    rej_d    = rej_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    busy_d   = 1'b0;
    mem_we_d = 1'b0;
    rd_d     = RD;
    err_d    = ERR;
    mem_a_d  = MEM_A;
    mem_wd_d = MEM_WD;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          state_d  = ACCESS;
          last_d   = win1;
          gnt0_d   = ~win1;
          gnt1_d   = win1;
          busy_d   = 1'b1;
          mem_a_d  = sel_a;
          mem_wd_d = sel_wd;
          mem_we_d = sel_we & ~rej;
          we_d     = sel_we;
          rej_d    = rej;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        done0_d = GNT0;
        done1_d = GNT1;
        err_d   = rej_q;
        if (!we_q && !rej_q) rd_d = MEM_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      rej_q   <= 1'b0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      DONE0   <= 1'b0;
      DONE1   <= 1'b0;
      RD      <= '0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      MEM_A   <= '0;
      MEM_WD  <= '0;
      MEM_WE  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      rej_q   <= rej_d;
      GNT0    <= gnt0_d;
      GNT1    <= gnt1_d;
      DONE0   <= done0_d;
      DONE1   <= done1_d;
      RD      <= rd_d;
      ERR     <= err_d;
      BUSY    <= busy_d;
      MEM_A   <= mem_a_d;
      MEM_WD  <= mem_wd_d;
      MEM_WE  <= mem_we_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte memory model plus an in-order scoreboard of
// expected completions (port, RD, ERR), built from a reference memory when requests are driven.
`timescale 1ns/1ps

module tb_dmem_arbiter;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 1024;

  logic         CLK, RST_N;
  logic         REQ0, REQ1, WE0, WE1;
  logic [W-1:0] A0, A1, WD0, WD1;
  logic         GNT0, GNT1, DONE0, DONE1, ERR, BUSY, MEM_WE;
  logic [W-1:0] RD, MEM_A, MEM_WD, MEM_RD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         port;
    logic [W-1:0] rd;
    logic         err;
  } exp_t;
  exp_t sbq[$];

  logic [7:0]   dmem    [DEPTH] = '{default: 8'h00};
  logic [7:0]   ref_mem [DEPTH] = '{default: 8'h00};
  logic [W-1:0] model_rd = '0;

  dmem_arbiter #(.Width(W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .RD(RD), .ERR(ERR), .BUSY(BUSY),
    .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int unsigned bidx(input logic [W-1:0] a, input int unsigned i);
    logic [W-1:0] t;
    t = (a + W'(i)) % W'(DEPTH);
    return t;
  endfunction

  function automatic logic exp_rej(input logic [W-1:0] a);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    return (a[1:0] != 2'b00) || (a > W'(DEPTH - 4));
`else
    return 1'b0;
`endif
  endfunction

  // Little-endian byte memory seen by the DUT
  assign MEM_RD = {dmem[bidx(MEM_A, 3)], dmem[bidx(MEM_A, 2)],
                   dmem[bidx(MEM_A, 1)], dmem[bidx(MEM_A, 0)]};

  always @(posedge CLK)
    if (MEM_WE)
      for (int i = 0; i < 4; i++) dmem[bidx(MEM_A, unsigned'(i))] <= MEM_WD[8*i +: 8];

  // Reference model: applies the access to ref_mem and queues the expected completion
  task automatic push_exp(input logic port, input logic we, input logic [W-1:0] a,
                          input logic [W-1:0] wd);
    exp_t e;
    logic rej;
    rej = exp_rej(a);
    if (!rej) begin
      if (we) for (int i = 0; i < 4; i++) ref_mem[bidx(a, unsigned'(i))] = wd[8*i +: 8];
      else model_rd = {ref_mem[bidx(a, 3)], ref_mem[bidx(a, 2)],
                       ref_mem[bidx(a, 1)], ref_mem[bidx(a, 0)]};
    end
    e.port = port; e.rd = model_rd; e.err = rej;
    sbq.push_back(e);
  endtask

  task automatic drive_req(input logic port, input logic we, input logic [W-1:0] a,
                           input logic [W-1:0] wd);
    if (port) begin REQ1 = 1'b1; WE1 = we; A1 = a; WD1 = wd; end
    else      begin REQ0 = 1'b1; WE0 = we; A0 = a; WD0 = wd; end
  endtask

  // One complete access on one port: grant-cycle and done-cycle checks against the scoreboard
  task automatic do_access(input logic port, input logic we, input logic [W-1:0] a,
                           input logic [W-1:0] wd, output int lat);
    exp_t e;
    logic granted;
    drive_req(port, we, a, wd);
    push_exp(port, we, a, wd);
    granted = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8 && !granted; c++) begin
      @(posedge CLK); #1;
      if ((port ? GNT1 : GNT0) === 1'b1) begin granted = 1'b1; lat = c; end
    end
    checks++;
    if (!granted) begin
      errors++;
      $display("FAIL grant_timeout port=%0d: no GNT, required GNT within 8 cycles", port);
      REQ0 = 1'b0; REQ1 = 1'b0;
      void'(sbq.pop_front());
      return;
    end
    checks++;
    if (BUSY !== 1'b1 || MEM_A !== a) begin
      errors++;
      $display("FAIL grant_cycle port=%0d: BUSY=%b MEM_A=%h, required BUSY=1 MEM_A=%h",
               port, BUSY, MEM_A, a);
    end
    checks++;
    if (MEM_WE !== (we & ~exp_rej(a))) begin
      errors++;
      $display("FAIL mem_we_grant a=%h: got %b, required %b", a, MEM_WE, we & ~exp_rej(a));
    end
    if (port) REQ1 = 1'b0; else REQ0 = 1'b0;
    @(posedge CLK); #1;
    e = sbq.pop_front();
    checks++;
    if ((port ? DONE1 : DONE0) !== 1'b1 || (port ? DONE0 : DONE1) !== 1'b0) begin
      errors++;
      $display("FAIL done port=%0d: DONE0=%b DONE1=%b, required only DONE%0d", port,
               DONE0, DONE1, port);
    end
    checks++;
    if (RD !== e.rd || ERR !== e.err) begin
      errors++;
      $display("FAIL done_data a=%h: RD=%h ERR=%b, required RD=%h ERR=%b", a, RD, ERR,
               e.rd, e.err);
    end
    checks++;
    if (MEM_WE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: MEM_WE=%b BUSY=%b, required 0 0", MEM_WE, BUSY);
    end
  endtask

  task automatic test_reset();
    REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; A0 = '0; A1 = '0; WD0 = '0; WD1 = '0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({GNT0, GNT1, DONE0, DONE1, ERR, BUSY, MEM_WE} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {GNT0, GNT1, DONE0, DONE1, ERR, BUSY, MEM_WE});
    end
    checks++;
    if (RD !== '0 || MEM_A !== '0 || MEM_WD !== '0) begin
      errors++;
      $display("FAIL reset_data: RD=%h MEM_A=%h MEM_WD=%h, required all 0", RD, MEM_A, MEM_WD);
    end
    RST_N = 1'b1;
    model_rd = '0;
    @(posedge CLK); #1;
  endtask

  task automatic test_store_load();
    int lat;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL load_latency: GNT after %0d cycles, required 1 (DONE at +2)", lat);
    end
  endtask

  task automatic test_tie();
    exp_t e;
    int   n;
    logic ord [4];
    int   cyc [4];
    RST_N = 1'b0; @(posedge CLK); #1; RST_N = 1'b1;
    model_rd = '0;
    sbq.delete();
    WE0 = 0; A0 = 32'h10; WE1 = 0; A1 = 32'h10; REQ0 = 1; REQ1 = 1;
    push_exp(1'b0, 1'b0, 32'h10, '0); push_exp(1'b1, 1'b0, 32'h10, '0);
    push_exp(1'b0, 1'b0, 32'h10, '0); push_exp(1'b1, 1'b0, 32'h10, '0);
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (GNT0 || GNT1) begin
        checks++;
        if (GNT0 === 1'b1 && GNT1 === 1'b1) begin
          errors++;
          $display("FAIL tie_overlap cycle %0d: GNT0=1 GNT1=1, required one-hot", c);
        end
        if (n < 4) begin ord[n] = GNT1; cyc[n] = c; end
        n++;
        if (GNT0) REQ0 = 1'b0;
        if (GNT1) REQ1 = 1'b0;
      end
      if (DONE0 || DONE1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL tie_extra_done cycle %0d: DONE0=%b DONE1=%b, required none", c,
                   DONE0, DONE1);
        end else begin
          e = sbq.pop_front();
          if (DONE1 !== e.port || DONE0 === DONE1 || RD !== e.rd || ERR !== e.err) begin
            errors++;
            $display("FAIL tie_done cycle %0d: DONE1=%b RD=%h ERR=%b, required DONE%0d RD=%h ERR=%b",
                     c, DONE1, RD, ERR, e.port, e.rd, e.err);
          end
          if (c < 7) begin if (DONE0) REQ0 = 1'b1; else REQ1 = 1'b1; end
        end
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL tie_count: %0d grants, required 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ord[k] !== 1'(k % 2) || cyc[k] !== 2 * k + 1) begin
          errors++;
          $display("FAIL tie_order grant %0d: port %0d at cycle %0d, required port %0d at cycle %0d",
                   k, ord[k], cyc[k], k % 2, 2 * k + 1);
        end
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_port1_store();
    int lat;
    do_access(1'b1, 1'b1, 32'h20, 32'h11223344, lat);
    do_access(1'b0, 1'b0, 32'h20, 32'h0, lat);
    checks++;
    if (dmem[32] !== 8'h44) begin
      errors++;
      $display("FAIL little_endian: byte 0x20=%h, required 44", dmem[32]);
    end
  endtask

  task automatic test_misaligned();
    int lat;
    do_access(1'b0, 1'b1, 32'h22,  32'hA5A5A5A5, lat);
    do_access(1'b0, 1'b1, 32'h3FE, 32'h5A5A5A5A, lat);
    do_access(1'b0, 1'b0, 32'h20,  32'h0, lat);
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    logic granted;
    logic first;
    int   n;
    drive_req(1'b0, 1'b1, 32'h40, 32'h12345678);
    granted = 1'b0;
    for (int c = 0; c < 8 && !granted; c++) begin
      @(posedge CLK); #1;
      if (GNT0 === 1'b1) granted = 1'b1;
    end
    RST_N = 1'b0; REQ0 = 1'b0;
    #1;
    checks++;
    if (!granted || MEM_WE !== 1'b0 || GNT0 !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: granted=%b MEM_WE=%b GNT0=%b BUSY=%b, required 1 0 0 0",
               granted, MEM_WE, GNT0, BUSY);
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: DONE0=%b, required 0", DONE0);
    end
    RST_N = 1'b1;
    model_rd = '0;
    WE0 = 0; A0 = 32'h10; WE1 = 0; A1 = 32'h10; REQ0 = 1; REQ1 = 1;
    push_exp(1'b0, 1'b0, 32'h10, '0); push_exp(1'b1, 1'b0, 32'h10, '0);
    n = 0; first = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK); #1;
      if (GNT0 || GNT1) begin
        if (n == 0) first = GNT1;
        n++;
        if (GNT0) REQ0 = 1'b0;
        if (GNT1) REQ1 = 1'b0;
      end
      if ((DONE0 || DONE1) && sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (DONE1 !== e.port || RD !== e.rd) begin
          errors++;
          $display("FAIL post_reset_done cycle %0d: DONE1=%b RD=%h, required DONE%0d RD=%h",
                   c, DONE1, RD, e.port, e.rd);
        end
      end
    end
    checks++;
    if (n !== 2 || first !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie: %0d grants first port %0d, required 2 grants first port 0",
               n, first);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n, dn;
    int   g [2];
    drive_req(1'b0, 1'b0, 32'h10, 32'h0);
    push_exp(1'b0, 1'b0, 32'h10, '0); push_exp(1'b0, 1'b0, 32'h10, '0);
    n = 0; dn = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK); #1;
      if (GNT0 === 1'b1) begin
        if (n < 2) g[n] = c;
        n++;
        if (n == 2) REQ0 = 1'b0;
      end
      if (DONE0 === 1'b1) begin
        dn++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_done cycle %0d: DONE0=1, required none", c);
        end else begin
          e = sbq.pop_front();
          if (RD !== e.rd || ERR !== e.err) begin
            errors++;
            $display("FAIL b2b_done cycle %0d: RD=%h ERR=%b, required RD=%h ERR=%b",
                     c, RD, ERR, e.rd, e.err);
          end
        end
      end
    end
    REQ0 = 1'b0;
    checks++;
    if (n !== 2 || dn !== 2 || g[0] !== 1 || g[1] !== 3) begin
      errors++;
      $display("FAIL b2b_timing: %0d grants at %0d,%0d with %0d DONE0, required 2 at 1,3 with 2",
               n, g[0], g[1], dn);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    test_reset();
    test_store_load();
    test_tie();
    test_port1_store();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer in front of the byte-addressed, little-endian data memory (combinational read, write on rising CLK). Port 0 is the core load/store unit and port 1 is the DMA/debug loader. Each access is latched, driven to the memory for exactly one cycle, and completed with a registered read-data/done pulse. Round-robin arbitration prevents starvation.

## Interface
- `Width`, 32, data and address width.
- `DEPTH`, 1024, memory size in bytes; the highest legal word address is `DEPTH-4`.
- `CLK` input 1: rising-edge clock.
- `RST_N` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `REQ0`/`REQ1` input 1: access request from port 0/1.
- `WE0`/`WE1` input 1: 1 = store word, 0 = load word.
- `A0`/`A1` input Width: byte address.
- `WD0`/`WD1` input Width: store data.
- `GNT0`/`GNT1` output 1: one-cycle pulse; the request was accepted and latched.
- `DONE0`/`DONE1` output 1: one-cycle pulse; the access is complete and `RD`/`ERR` are valid.
- `RD` output Width: load data, registered, shared by both ports.
- `ERR` output 1: access rejected; valid together with `DONE*`.
- `BUSY` output 1: high while in state ACCESS.
- `MEM_A` output Width: memory address.
- `MEM_WD` output Width: memory write data.
- `MEM_WE` output 1: memory write enable.
- `MEM_RD` input Width: memory combinational read data.

## Operation
- States: IDLE and ACCESS. Reset enters IDLE.
- **IDLE**
  - At each rising edge, sample `REQ0`/`REQ1`.
  - If either is high, pick a winner, latch its `A`/`WD`/`WE` into `MEM_A`/`MEM_WD`/a write flag, record the winner as last-granted, and go to ACCESS.
  - Otherwise stay in IDLE.
- **Arbitration**
  - A single request wins.
  - When both request, the port NOT last granted wins.
  - The last-granted pointer resets to port 1, so port 0 wins the first tie.
- **ACCESS** (exactly one cycle)
  - `GNT` of the winner = 1. `MEM_WE` = latched write flag AND NOT rejected.
  - At the closing edge:
    - The memory performs the write if enabled.
    - `RD` <= `MEM_RD` for a load; `RD` holds its value for a store or a rejected access.
    - `DONE` of the winner <= 1 for one cycle.
    - `ERR` <= rejected flag.
    - Return to IDLE.
- `REQ` is ignored during ACCESS.
- A requester must hold `REQ`/`A`/`WD`/`WE` stable until it sees `GNT`, and must drop `REQ` in its `GNT` cycle.
- `REQ` still high in the `DONE` cycle counts as a new request, sampled at that cycle's closing edge.
- `MEM_A`/`MEM_WD` hold their last latched values in IDLE. `MEM_WE` is 0 outside ACCESS.
- Rejected flag: see Configuration; it is 0 when the checks are compiled out.

## Timing
- Reset values: `GNT0`=`GNT1`=`DONE0`=`DONE1`=0, `RD`=0, `ERR`=0, `BUSY`=0, `MEM_A`=0, `MEM_WD`=0, `MEM_WE`=0. State = IDLE, last-granted = port 1.
- `REQ` sampled high at edge N:
  - `GNT`, `BUSY` and `MEM_*` are valid in cycle N..N+1.
  - The memory write occurs at edge N+1.
  - `DONE`/`RD`/`ERR` are valid in cycle N+1..N+2.
- Latency: 2 cycles from request sample to `DONE`. Peak throughput: one access per 2 cycles.
- Both ports continuously requesting: grants alternate 0,1,0,1,… with each grant 2 cycles apart.
- `RST_N` asserted mid-ACCESS: state goes to IDLE and `MEM_WE`, `GNT`, `DONE`, `BUSY` clear asynchronously. No write is guaranteed and no `DONE` is issued. The requester re-requests after reset.
- `RD` is registered. `MEM_RD` is never passed combinationally to `RD`.

## Configuration
- `DMEM_ARB_ALIGN_CHK_EN` defined:
  - The latched access is rejected if `A[1:0]` != 0 or `A` > `DEPTH-4`.
  - On rejection: `MEM_WE` stays 0, `RD` is unchanged, `ERR`=1 with `DONE`.
- Not defined:
  - No checks are made; `ERR` is constant 0.
  - Every access is passed to the memory unmodified.

## Test plan
- Port 0 store `A0`=0x10, `WD0`=0xDEADBEEF, then port 0 load `A0`=0x10 -> `MEM_WE`=1 for exactly one cycle; the load's `DONE0` comes 2 cycles after its `REQ` sample with `RD`=0xDEADBEEF and `ERR`=0.
- `REQ0` and `REQ1` both high from reset for 8 cycles, each port re-requesting after `DONE` -> grant order 0,1,0,1 with `GNT` pulses 2 cycles apart; `GNT0` and `GNT1` never overlap.
- Port 1 store 0x11223344 to 0x20, then port 0 load from 0x20 -> `RD`=0x11223344; byte at 0x20 = 0x44 (little endian).
- With `DMEM_ARB_ALIGN_CHK_EN`: port 0 store to 0x22, then to 0x3FE -> `ERR`=1 with `DONE0` both times, `MEM_WE` never 1, and a later load from 0x20 returns the prior value. Without the macro: `ERR`=0.
- `RST_N` pulled low during the ACCESS cycle of a store -> `MEM_WE`, `GNT0`, `BUSY` go to 0 immediately, no `DONE0`, and the next tie after reset grants port 0.
- `REQ0` held high through its `DONE0` cycle -> a second grant follows 2 cycles after the first, with `DONE0` pulsing twice.
